// File: rtl/call_request_conditioner.sv
// Input conditioning for the freight-elevator controller: synchronizes and debounces
// call buttons, limit switches and the overweight sensor, latches calls and selects the nearest one.
module call_request_conditioner #(
    parameter int DEB_CYCLES = 250000,
    parameter int CNT_W      = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] p_raw,
    input  logic [3:0] fc_raw,
    input  logic       sp_raw,
    input  logic [3:0] served,
    output logic [3:0] p_pulse,
    output logic [3:0] call_pending,
    output logic       call_valid,
    output logic [1:0] call_next,
    output logic [3:0] fc_db,
    output logic [1:0] floor_pos,
    output logic       at_floor,
    output logic       fc_fault,
    output logic       sp_db
);

    localparam int              CH       = 9;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CH-1:0]    raw_all;
    logic [CH-1:0]    sync_p0;
    logic [CH-1:0]    sync_p1;
    logic [CH-1:0]    stable_p2;
    logic [CNT_W-1:0] cnt_p2 [CH];
    logic [3:0]       p_prev_p3;
    logic [3:0]       rise;
    logic [3:0]       pending_nxt;
    logic [2:0]       fc_count;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] floor_dist(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // Channel order: [3:0] pushbuttons, [7:4] limit switches, [8] overweight
    assign raw_all = {sp_raw, fc_raw, p_raw};

    // Stage p0/p1: two-flop synchronizer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw_all;
            sync_p1 <= sync_p0;
        end
    end

    // Stage p2: qualification; any return to the stable level restarts the count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_p2 <= '0;
            for (int i = 0; i < CH; i++) cnt_p2[i] <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (sync_p1[i] != stable_p2[i]) begin
                    if (cnt_p2[i] == CNT_LAST) begin
                        stable_p2[i] <= sync_p1[i];
                        cnt_p2[i]    <= '0;
                    end else begin
                        cnt_p2[i] <= cnt_p2[i] + 1'b1;
                    end
                end else begin
                    cnt_p2[i] <= '0;
                end
            end
        end
    end

    assign fc_db = stable_p2[7:4];
    assign sp_db = stable_p2[8];
    assign rise  = stable_p2[3:0] & ~p_prev_p3;
    assign fc_count = popcount4(fc_db);

    always_comb begin
        pending_nxt = call_pending;
        for (int i = 0; i < 4; i++) begin
            if (served[i])
                pending_nxt[i] = 1'b0;
            else if (rise[i] && !sp_db && !(at_floor && floor_pos == 2'(i)))
                pending_nxt[i] = 1'b1;
        end
    end

    // Stage p3: edge detect, call latch and floor tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_prev_p3    <= '0;
            p_pulse      <= '0;
            call_pending <= '0;
            floor_pos    <= '0;
            at_floor     <= 1'b0;
            fc_fault     <= 1'b0;
        end else begin
            p_prev_p3    <= stable_p2[3:0];
            p_pulse      <= rise;
            call_pending <= pending_nxt;
            at_floor     <= (fc_count == 3'd1);
            fc_fault     <= fc_fault | (fc_count >= 3'd2);
            if (fc_count == 3'd1)
                floor_pos <= onehot_index(fc_db);
        end
    end

    assign call_valid = |call_pending;

    always_comb begin
        logic [1:0] best_dist;
        logic [1:0] d;
        logic       found;
        call_next = 2'd0;
        best_dist = 2'd3;
        d         = 2'd0;
        found     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (call_pending[i]) begin
                d = floor_dist(2'(i), floor_pos);
                if (!found || d < best_dist) begin
                    call_next = 2'(i);
                    best_dist = d;
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_call_request_conditioner.sv
// Directed bench for call_request_conditioner with DEB_CYCLES = 4.
module tb_call_request_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] p_raw;
    logic [3:0] fc_raw;
    logic       sp_raw;
    logic [3:0] served;
    logic [3:0] p_pulse;
    logic [3:0] call_pending;
    logic       call_valid;
    logic [1:0] call_next;
    logic [3:0] fc_db;
    logic [1:0] floor_pos;
    logic       at_floor;
    logic       fc_fault;
    logic       sp_db;

    int n_tests = 0;
    int n_fail  = 0;

    call_request_conditioner #(.DEB_CYCLES(4), .CNT_W(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .p_raw        (p_raw),
        .fc_raw       (fc_raw),
        .sp_raw       (sp_raw),
        .served       (served),
        .p_pulse      (p_pulse),
        .call_pending (call_pending),
        .call_valid   (call_valid),
        .call_next    (call_next),
        .fc_db        (fc_db),
        .floor_pos    (floor_pos),
        .at_floor     (at_floor),
        .fc_fault     (fc_fault),
        .sp_db        (sp_db)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges; returns at the following falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        p_raw  = '0;
        fc_raw = '0;
        sp_raw = 1'b0;
        served = '0;
        reset  = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
    endtask

    initial begin
        // Reset with all raw inputs high
        reset  = 1'b0;
        p_raw  = 4'hF;
        fc_raw = 4'hF;
        sp_raw = 1'b1;
        served = '0;
        step(4);
        check("rst_p_pulse", 32'(p_pulse), 0);
        check("rst_pending", 32'(call_pending), 0);
        check("rst_valid", 32'(call_valid), 0);
        check("rst_next", 32'(call_next), 0);
        check("rst_fc_db", 32'(fc_db), 0);
        check("rst_floor", 32'(floor_pos), 0);
        check("rst_at_floor", 32'(at_floor), 0);
        check("rst_fault", 32'(fc_fault), 0);
        check("rst_sp_db", 32'(sp_db), 0);
        reset = 1'b1;
        step(5);
        check("rel_fc_db_e5", 32'(fc_db), 0);
        step(1);
        check("rel_fc_db_e6", 32'(fc_db), 'hF);
        check("rel_sp_db_e6", 32'(sp_db), 1);
        check("rel_pulse_e6", 32'(p_pulse), 0);
        check("rel_fault_e6", 32'(fc_fault), 0);
        step(1);
        check("rel_pulse_e7", 32'(p_pulse), 'hF);
        check("rel_fault_e7", 32'(fc_fault), 1);
        check("rel_pend_sp", 32'(call_pending), 0);
        step(1);
        check("rel_pulse_e8", 32'(p_pulse), 0);

        // Bounce on P2 never qualifies
        do_reset();
        p_raw[1] = 1'b1; step(3);
        p_raw[1] = 1'b0; step(1);
        p_raw[1] = 1'b1; step(3);
        p_raw[1] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            check("bounce_pulse", 32'(p_pulse), 0);
        end
        check("bounce_pend", 32'(call_pending), 0);
        p_raw[1] = 1'b1;
        step(6);
        check("hold_pulse_e6", 32'(p_pulse), 0);
        check("hold_pend_e6", 32'(call_pending), 0);
        step(1);
        check("hold_pulse_e7", 32'(p_pulse), 'h2);
        check("hold_pend_e7", 32'(call_pending), 'h2);
        check("hold_valid", 32'(call_valid), 1);
        check("hold_next", 32'(call_next), 1);
        step(1);
        check("hold_pulse_e8", 32'(p_pulse), 0);
        check("hold_pend_e8", 32'(call_pending), 'h2);

        // Served beats a same-edge rise
        served = 4'b0010; step(1); served = '0;
        check("served_clr", 32'(call_pending), 0);
        p_raw = 4'b0100; step(7);
        check("race_setup", 32'(call_pending), 'h4);
        p_raw = '0; step(8);
        check("race_release", 32'(call_pending), 'h4);
        p_raw = 4'b0100; step(6);
        served = 4'b0100; step(1); served = '0;
        check("race_pend", 32'(call_pending), 0);
        check("race_pulse", 32'(p_pulse), 'h4);
        step(1);
        check("race_valid", 32'(call_valid), 0);
        check("race_next", 32'(call_next), 0);
        p_raw = '0; step(8);

        // Suppression: car already at floor 2, then overweight
        fc_raw = 4'b0010; step(7);
        check("sup_floor", 32'(floor_pos), 1);
        check("sup_at_floor", 32'(at_floor), 1);
        check("sup_fault", 32'(fc_fault), 0);
        p_raw = 4'b0010; step(7);
        check("sup_here_pulse", 32'(p_pulse), 'h2);
        check("sup_here_pend", 32'(call_pending), 0);
        p_raw = '0; sp_raw = 1'b1; step(6);
        check("sup_sp_db", 32'(sp_db), 1);
        step(2);
        p_raw = 4'b1000; step(7);
        check("sup_sp_pulse", 32'(p_pulse), 'h8);
        check("sup_sp_pend", 32'(call_pending), 0);
        p_raw = '0; sp_raw = 1'b0; step(8);

        // Nearest-call selection
        fc_raw = 4'b0100; step(8);
        check("near_floor2", 32'(floor_pos), 2);
        p_raw = 4'b1001; step(7);
        check("near_pend_9", 32'(call_pending), 'h9);
        check("near_next_3", 32'(call_next), 3);
        p_raw = '0; step(8);
        fc_raw = 4'b0010; step(8);
        check("near_floor1", 32'(floor_pos), 1);
        check("near_next_f1", 32'(call_next), 0);
        served = 4'b1001; step(1); served = '0;
        p_raw = 4'b0101; step(7);
        check("near_pend_5", 32'(call_pending), 'h5);
        check("near_tie", 32'(call_next), 0);
        served = 4'b0001; step(1); served = '0;
        check("near_only2", 32'(call_next), 2);
        served = 4'b0100; step(1); served = '0;
        check("near_empty_v", 32'(call_valid), 0);
        check("near_empty_n", 32'(call_next), 0);
        p_raw = '0; step(8);

        // Reset in the middle of operation
        fc_raw = 4'b0001; step(8);
        check("mid_floor0", 32'(floor_pos), 0);
        p_raw = 4'b1010; step(7);
        check("mid_pend", 32'(call_pending), 'hA);
        p_raw = '0; step(8);
        fc_raw = 4'b0011; step(8);
        check("mid_fault", 32'(fc_fault), 1);
        p_raw = 4'b0001; step(4);
        reset = 1'b0; step(1); reset = 1'b1;
        check("mid_rst_pend", 32'(call_pending), 0);
        check("mid_rst_fault", 32'(fc_fault), 0);
        check("mid_rst_fc_db", 32'(fc_db), 0);
        check("mid_rst_valid", 32'(call_valid), 0);
        step(6);
        check("mid_req_fc_db", 32'(fc_db), 'h3);
        check("mid_req_pend_e6", 32'(call_pending), 0);
        step(1);
        check("mid_req_pulse", 32'(p_pulse), 'h1);
        check("mid_req_pend_e7", 32'(call_pending), 'h1);
        check("mid_req_fault", 32'(fc_fault), 1);
        check("mid_req_atf", 32'(at_floor), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
